// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage MIPS pipeline.
// Generates EX-stage forwarding selects, load-use / mult-div stalls, branch and
// jump flushes, and sequences the multicycle MUL/DIV unit through IDLE/BUSY/DONE.
// Optional feature macro: HAZARD_PERF_EN adds StallCnt/FlushCnt performance counters.
module hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs_DE,
   input  logic [4:0] Rt_DE,
   input  logic [4:0] Rs_EX,
   input  logic [4:0] Rt_EX,
   input  logic [4:0] WriteReg_EX,
   input  logic [4:0] WriteReg_ME,
   input  logic [4:0] WriteReg_WB,
   input  logic       RegWrite_EX,
   input  logic       RegWrite_ME,
   input  logic       RegWrite_WB,
   input  logic       MemToReg_EX,
   input  logic       Jump_DE,
   input  logic       PcSrc_ME,
   input  logic       MulDiv_DE,
   input  logic       MfHiLo_DE,
   input  logic       MulDivStart_EX,
   input  logic       IsDiv_EX,
   output logic       Stall_FE,
   output logic       Stall_DE,
   output logic       Flush_DE,
   output logic       Flush_EX,
   output logic       Flush_ME,
   output logic [1:0] ForwardA_EX,
   output logic [1:0] ForwardB_EX,
   output logic       MulDivBusy,
   output logic       MulDivDone
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] StallCnt,
   output logic [31:0] FlushCnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   // Counter preload values: BUSY lasts LAT cycles counting LAT-1 down to 0.
   localparam logic [CNT_W-1:0] LD_MUL = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] LD_DIV = CNT_W'(DIV_LAT - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             w_launch, w_lu, w_md, w_stall;

   // Forwarding select: ME (10) has priority over WB (01); $0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic       we_me,
                                          input logic [4:0] wr_me,
                                          input logic       we_wb,
                                          input logic [4:0] wr_wb,
                                          input logic [4:0] src);
      if (we_me && (wr_me != 5'd0) && (wr_me == src))
         return 2'b10;
      else if (we_wb && (wr_wb != 5'd0) && (wr_wb == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // A mult/div on the wrong path (branch taken in ME) must never launch.
   assign w_launch = MulDivStart_EX && (r_state == S_IDLE) && !PcSrc_ME;
   assign w_lu     = MemToReg_EX && RegWrite_EX && (WriteReg_EX != 5'd0) &&
                     ((WriteReg_EX == Rs_DE) || (WriteReg_EX == Rt_DE));
   assign w_md     = (MulDiv_DE || MfHiLo_DE) &&
                     ((r_state == S_BUSY) || ((r_state == S_IDLE) && w_launch));
   assign w_stall  = (w_lu || w_md) && !PcSrc_ME;

   assign MulDivBusy = (r_state == S_BUSY);
   assign MulDivDone = (r_state == S_DONE);

   // FSM state and busy counter register; reset aborts any operation without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // FSM next state and counter: load on launch, count down in BUSY, single DONE cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_launch) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = IsDiv_EX ? LD_DIV : LD_MUL;
            end
         end
         S_BUSY: begin
            if (r_cnt == '0)
               w_state_nxt = S_DONE;
            else
               w_cnt_nxt = r_cnt - CNT_W'(1);
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Stall/flush/forward outputs; a taken branch overrides any stall, reset forces flushes.
   always_comb begin
      Stall_FE    = 1'b0;
      Stall_DE    = 1'b0;
      Flush_DE    = 1'b1;
      Flush_EX    = 1'b1;
      Flush_ME    = 1'b1;
      ForwardA_EX = 2'b00;
      ForwardB_EX = 2'b00;
      if (!reset) begin
         ForwardA_EX = fwd_sel(RegWrite_ME, WriteReg_ME, RegWrite_WB, WriteReg_WB, Rs_EX);
         ForwardB_EX = fwd_sel(RegWrite_ME, WriteReg_ME, RegWrite_WB, WriteReg_WB, Rt_EX);
         Stall_FE    = w_stall;
         Stall_DE    = w_stall;
         Flush_EX    = w_stall || PcSrc_ME;
         Flush_ME    = PcSrc_ME;
         // A jump held by a stall flushes only once the stall releases.
         Flush_DE    = PcSrc_ME || (Jump_DE && !w_stall);
      end
   end

`ifdef HAZARD_PERF_EN
   // Performance counters: stall cycles and flush cycles, wrapping, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (Stall_DE)
            StallCnt <= StallCnt + 32'd1;
         if (PcSrc_ME || Flush_DE)
            FlushCnt <= FlushCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: table vectors for forwarding/stall/flush rules,
// hand sequences for multi-cycle cases, and randomized stimulus against a model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs_DE, Rt_DE, Rs_EX, Rt_EX, WriteReg_EX, WriteReg_ME, WriteReg_WB;
   logic       RegWrite_EX, RegWrite_ME, RegWrite_WB, MemToReg_EX, Jump_DE, PcSrc_ME;
   logic       MulDiv_DE, MfHiLo_DE, MulDivStart_EX, IsDiv_EX;
   logic       Stall_FE, Stall_DE, Flush_DE, Flush_EX, Flush_ME;
   logic [1:0] ForwardA_EX, ForwardB_EX;
   logic       MulDivBusy, MulDivDone;
`ifdef HAZARD_PERF_EN
   logic [31:0] StallCnt, FlushCnt;
   logic [31:0] m_sc, m_fc;
`endif

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .Rs_DE(Rs_DE), .Rt_DE(Rt_DE), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
      .WriteReg_EX(WriteReg_EX), .WriteReg_ME(WriteReg_ME), .WriteReg_WB(WriteReg_WB),
      .RegWrite_EX(RegWrite_EX), .RegWrite_ME(RegWrite_ME), .RegWrite_WB(RegWrite_WB),
      .MemToReg_EX(MemToReg_EX), .Jump_DE(Jump_DE), .PcSrc_ME(PcSrc_ME),
      .MulDiv_DE(MulDiv_DE), .MfHiLo_DE(MfHiLo_DE),
      .MulDivStart_EX(MulDivStart_EX), .IsDiv_EX(IsDiv_EX),
      .Stall_FE(Stall_FE), .Stall_DE(Stall_DE), .Flush_DE(Flush_DE),
      .Flush_EX(Flush_EX), .Flush_ME(Flush_ME),
      .ForwardA_EX(ForwardA_EX), .ForwardB_EX(ForwardB_EX),
      .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
`ifdef HAZARD_PERF_EN
      , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: remaining BUSY cycles and a pending done cycle.
   int   m_left = 0;
   bit   m_done = 1'b0;
   // Expected values for the current cycle.
   logic [1:0] e_fa, e_fb;
   logic       e_sfe, e_sde, e_fde, e_fex, e_fme, e_busy, e_done, e_launch;
   // Observed DUT values at the last check point.
   logic [1:0] o_fa, o_fb;
   logic       o_sde, o_sfe, o_fde, o_fex, o_fme, o_busy, o_done;

   typedef struct {
      logic [4:0] rs_de, rt_de, rs_ex, rt_ex, wr_ex, wr_me, wr_wb;
      logic       we_ex, we_me, we_wb, mem_ex, jump, pcsrc;
      logic [1:0] fa, fb;
      logic       stall, fde, fex, fme;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd(input logic [4:0] src);
      if (RegWrite_ME && WriteReg_ME != 0 && WriteReg_ME == src) return 2'd2;
      if (RegWrite_WB && WriteReg_WB != 0 && WriteReg_WB == src) return 2'd1;
      return 2'd0;
   endfunction

   task automatic model_comb();
      bit idle, busy, lu, md, st;
      idle = (m_left == 0) && !m_done;
      busy = (m_left > 0);
      e_launch = MulDivStart_EX && idle && !PcSrc_ME;
      lu = MemToReg_EX && RegWrite_EX && WriteReg_EX != 0 &&
           (WriteReg_EX == Rs_DE || WriteReg_EX == Rt_DE);
      md = (MulDiv_DE || MfHiLo_DE) && (busy || e_launch);
      st = (lu || md) && !PcSrc_ME;
      e_busy = busy;
      e_done = m_done;
      if (reset) begin
         e_fa = 0; e_fb = 0; e_sfe = 0; e_sde = 0; e_fde = 1; e_fex = 1; e_fme = 1;
      end else begin
         e_fa = fwd(Rs_EX); e_fb = fwd(Rt_EX);
         e_sfe = st; e_sde = st;
         e_fex = st || PcSrc_ME;
         e_fme = PcSrc_ME;
         e_fde = PcSrc_ME || (Jump_DE && !st);
      end
   endtask

   task automatic model_seq();
      if (reset) begin
         m_left = 0; m_done = 0;
`ifdef HAZARD_PERF_EN
         m_sc = 0; m_fc = 0;
`endif
      end else begin
`ifdef HAZARD_PERF_EN
         if (e_sde) m_sc = m_sc + 1;
         if (PcSrc_ME || e_fde) m_fc = m_fc + 1;
`endif
         if (e_launch) begin
            m_left = IsDiv_EX ? 32 : 4;
            m_done = 0;
         end else if (m_left > 0) begin
            m_done = (m_left == 1);
            m_left--;
         end else begin
            m_done = 0;
         end
      end
   endtask

   // One clock cycle: check at the falling edge, advance the model at the rising edge.
   task automatic cyc();
      @(negedge clk);
      model_comb();
      o_fa = ForwardA_EX; o_fb = ForwardB_EX; o_sfe = Stall_FE; o_sde = Stall_DE;
      o_fde = Flush_DE; o_fex = Flush_EX; o_fme = Flush_ME;
      o_busy = MulDivBusy; o_done = MulDivDone;
      chk("ForwardA_EX", o_fa, e_fa);
      chk("ForwardB_EX", o_fb, e_fb);
      chk("Stall_FE", o_sfe, e_sfe);
      chk("Stall_DE", o_sde, e_sde);
      chk("Flush_DE", o_fde, e_fde);
      chk("Flush_EX", o_fex, e_fex);
      chk("Flush_ME", o_fme, e_fme);
      chk("MulDivBusy", o_busy, e_busy);
      chk("MulDivDone", o_done, e_done);
`ifdef HAZARD_PERF_EN
      chk("StallCnt", StallCnt, m_sc);
      chk("FlushCnt", FlushCnt, m_fc);
`endif
      @(posedge clk);
      model_seq();
      #1;
   endtask

   task automatic clear_inputs();
      Rs_DE = 0; Rt_DE = 0; Rs_EX = 0; Rt_EX = 0;
      WriteReg_EX = 0; WriteReg_ME = 0; WriteReg_WB = 0;
      RegWrite_EX = 0; RegWrite_ME = 0; RegWrite_WB = 0; MemToReg_EX = 0;
      Jump_DE = 0; PcSrc_ME = 0; MulDiv_DE = 0; MfHiLo_DE = 0;
      MulDivStart_EX = 0; IsDiv_EX = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1; cyc();
      reset = 0;
   endtask

   initial begin
      int busy_cnt, done_at, done_seen;
      clear_inputs();
      reset = 1;
      // Reset state
      cyc();
      cyc();
      chk("reset Stall_FE", o_sfe, 0);
      chk("reset Flush_DE", o_fde, 1);
      chk("reset Flush_EX", o_fex, 1);
      chk("reset Flush_ME", o_fme, 1);
      chk("reset MulDivBusy", o_busy, 0);
      chk("reset MulDivDone", o_done, 0);
      reset = 0;

      // Combinational rule table (FSM idle, no mult/div activity)
      tbl[0]  = '{1,2,8,3, 0,8,8, 0,1,1,0,0,0, 2'd2,2'd0, 0,0,0,0};
      tbl[1]  = '{1,2,0,0, 0,0,0, 0,1,1,0,0,0, 2'd0,2'd0, 0,0,0,0};
      tbl[2]  = '{1,2,5,5, 0,5,5, 0,0,1,0,0,0, 2'd1,2'd1, 0,0,0,0};
      tbl[3]  = '{1,2,6,7, 0,7,6, 0,1,1,0,0,0, 2'd1,2'd2, 0,0,0,0};
      tbl[4]  = '{1,9,0,0, 9,0,0, 1,0,0,1,0,0, 2'd0,2'd0, 1,0,1,0};
      tbl[5]  = '{0,2,0,0, 0,0,0, 1,0,0,1,0,0, 2'd0,2'd0, 0,0,0,0};
      tbl[6]  = '{1,9,0,0, 9,0,0, 1,0,0,1,0,1, 2'd0,2'd0, 0,1,1,1};
      tbl[7]  = '{1,2,0,0, 0,0,0, 0,0,0,0,1,0, 2'd0,2'd0, 0,1,0,0};
      tbl[8]  = '{9,2,0,0, 9,0,0, 1,0,0,1,1,0, 2'd0,2'd0, 1,0,1,0};
      tbl[9]  = '{1,9,0,0, 9,0,0, 1,0,0,0,0,0, 2'd0,2'd0, 0,0,0,0};
      tbl[10] = '{1,9,0,0, 9,0,0, 0,0,0,1,0,0, 2'd0,2'd0, 0,0,0,0};
      for (int i = 0; i < 11; i++) begin
         clear_inputs();
         Rs_DE = tbl[i].rs_de; Rt_DE = tbl[i].rt_de; Rs_EX = tbl[i].rs_ex; Rt_EX = tbl[i].rt_ex;
         WriteReg_EX = tbl[i].wr_ex; WriteReg_ME = tbl[i].wr_me; WriteReg_WB = tbl[i].wr_wb;
         RegWrite_EX = tbl[i].we_ex; RegWrite_ME = tbl[i].we_me; RegWrite_WB = tbl[i].we_wb;
         MemToReg_EX = tbl[i].mem_ex; Jump_DE = tbl[i].jump; PcSrc_ME = tbl[i].pcsrc;
         cyc();
         chk($sformatf("tbl%0d ForwardA", i), o_fa, tbl[i].fa);
         chk($sformatf("tbl%0d ForwardB", i), o_fb, tbl[i].fb);
         chk($sformatf("tbl%0d Stall_FE", i), o_sfe, tbl[i].stall);
         chk($sformatf("tbl%0d Stall_DE", i), o_sde, tbl[i].stall);
         chk($sformatf("tbl%0d Flush_DE", i), o_fde, tbl[i].fde);
         chk($sformatf("tbl%0d Flush_EX", i), o_fex, tbl[i].fex);
         chk($sformatf("tbl%0d Flush_ME", i), o_fme, tbl[i].fme);
      end

      // Load-use costs one bubble: next cycle EX holds the bubble, stall releases
      do_reset();
      MemToReg_EX = 1; RegWrite_EX = 1; WriteReg_EX = 9; Rt_DE = 9;
      cyc();
      chk("lu stall cycle", o_sde, 1);
      MemToReg_EX = 0; RegWrite_EX = 0; WriteReg_EX = 0;
      cyc();
      chk("lu released", o_sde, 0);
      chk("lu flush_ex released", o_fex, 0);

      // Divide latency with mfhi held in DE
      do_reset();
      MulDivStart_EX = 1; IsDiv_EX = 1; MfHiLo_DE = 1;
      cyc();
      chk("div launch stall", o_sde, 1);
      MulDivStart_EX = 0; IsDiv_EX = 0;
      busy_cnt = 0; done_at = 0; done_seen = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         if (o_busy) begin
            busy_cnt++;
            chk("div mfhi stalled in BUSY", o_sde, 1);
         end
         if (o_done) begin
            done_seen++;
            done_at = k;
            chk("div mfhi released in DONE", o_sde, 0);
         end
      end
      chk("div busy cycles", busy_cnt, 32);
      chk("div done cycle", done_at, 33);
      chk("div done pulses", done_seen, 1);

      // Wrong-path launch with taken branch
      do_reset();
      MulDivStart_EX = 1; PcSrc_ME = 1;
      cyc();
      MulDivStart_EX = 0; PcSrc_ME = 0;
      cyc();
      chk("wrongpath busy", o_busy, 0);
      cyc();
      chk("wrongpath done", o_done, 0);

      // Reset at BUSY cycle 3 of a multiply
      do_reset();
      MulDivStart_EX = 1; MulDiv_DE = 1;
      cyc();
      MulDivStart_EX = 0; MulDiv_DE = 0;
      cyc(); cyc();
      reset = 1;
      cyc();
      chk("mul busy before abort", o_busy, 1);
      reset = 0;
      cyc();
      chk("abort busy", o_busy, 0);
`ifdef HAZARD_PERF_EN
      chk("abort StallCnt", StallCnt, 0);
      chk("abort FlushCnt", FlushCnt, 0);
`endif
      done_seen = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (o_done) done_seen++;
      end
      chk("abort no done", done_seen, 0);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         reset          = ($urandom_range(0, 49) == 0);
         Rs_DE          = 5'($urandom_range(0, 3));
         Rt_DE          = 5'($urandom_range(0, 3));
         Rs_EX          = 5'($urandom_range(0, 3));
         Rt_EX          = 5'($urandom_range(0, 3));
         WriteReg_EX    = 5'($urandom_range(0, 3));
         WriteReg_ME    = 5'($urandom_range(0, 3));
         WriteReg_WB    = 5'($urandom_range(0, 3));
         RegWrite_EX    = 1'($urandom_range(0, 1));
         RegWrite_ME    = 1'($urandom_range(0, 1));
         RegWrite_WB    = 1'($urandom_range(0, 1));
         MemToReg_EX    = 1'($urandom_range(0, 1));
         Jump_DE        = ($urandom_range(0, 3) == 0);
         PcSrc_ME       = ($urandom_range(0, 5) == 0);
         MulDiv_DE      = ($urandom_range(0, 3) == 0);
         MfHiLo_DE      = ($urandom_range(0, 3) == 0);
         MulDivStart_EX = ($urandom_range(0, 5) == 0);
         IsDiv_EX       = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
